// File: rtl/adc_spi_rx_pkg.sv
// Shared state encoding and framing constants for the dual-channel ADC SPI reader.
package adc_spi_rx_pkg;
  typedef enum logic [2:0] {IDLE, CONV, GAP, SHIFT, DONE} state_t;

  localparam int FRAME_LEN = 34;
  localparam int SMP_W     = 14;
  localparam int CHA_MSB   = 31;
  localparam int CHA_LSB   = 18;
  localparam int CHB_MSB   = 15;
  localparam int CHB_LSB   = 2;
endpackage

// File: rtl/adc_spi_rx_sck_gen.sv
// SCK half-period generator: idles low while disabled, strobes on the cycle sck rises or falls.
module sck_gen #(
  parameter int HALF = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int HW = $clog2(HALF + 1);
  localparam logic [HW-1:0] HLAST = HW'(HALF - 1);

  logic [HW-1:0] hcnt;
  logic          tick;

  assign tick = en && (hcnt == HLAST);
  assign rise = tick & ~sck;
  assign fall = tick & sck;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      sck  <= 1'b0;
    end else if (!en) begin
      hcnt <= '0;
      sck  <= 1'b0;
    end else if (tick) begin
      hcnt <= '0;
      sck  <= ~sck;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end
endmodule

// File: rtl/adc_spi_rx.sv
// SPI read master for the dual 14-bit ADC: conversion pulse, 34-edge frame capture, parallel words.
module adc_spi_rx
  import adc_spi_rx_pkg::*;
#(
  parameter int HALF    = 2,
  parameter int CONVLEN = 4,
  parameter int FRAME   = FRAME_LEN
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clockenable,
  input  logic             miso,
  output logic             adcconv,
  output logic             sck,
  output logic [SMP_W-1:0] datos_a,
  output logic [SMP_W-1:0] datos_b,
  output logic             valid,
  output logic             busy
);
  localparam int CMAX = (CONVLEN > HALF) ? CONVLEN : HALF;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int EW   = $clog2(FRAME + 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONVLEN - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(HALF - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(FRAME);

  state_t           state;
  logic             ce_q;
  logic             start;
  logic [CW-1:0]    cnt;
  logic [EW-1:0]    edges;
  logic [FRAME-1:0] sr;
  logic             sck_en, rise, fall;

  assign start  = clockenable & ~ce_q;
  assign sck_en = (state == SHIFT);

  sck_gen #(.HALF(HALF)) u_sck (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (sck_en),
    .sck    (sck),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ce_q    <= 1'b0;
      cnt     <= '0;
      edges   <= '0;
      sr      <= '0;
      adcconv <= 1'b0;
      datos_a <= '0;
      datos_b <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ce_q  <= clockenable;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          edges <= '0;
          if (start) begin
            state   <= CONV;
            adcconv <= 1'b1;
            busy    <= 1'b1;
          end
        end
        CONV: begin
          if (cnt == CONV_LAST) begin
            cnt     <= '0;
            adcconv <= 1'b0;
            state   <= GAP;
          end else cnt <= cnt + 1'b1;
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= SHIFT;
          end else cnt <= cnt + 1'b1;
        end
        SHIFT: begin
          if (rise) begin
            sr    <= {sr[FRAME-2:0], miso};
            edges <= edges + 1'b1;
          end
          // the falling edge after the last rise closes the frame
          if (fall && edges == EDGE_LAST) begin
            state   <= DONE;
            datos_a <= sr[CHA_MSB:CHA_LSB];
            datos_b <= sr[CHB_MSB:CHB_LSB];
            valid   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_spi_rx.sv
// Randomized bench for adc_spi_rx with a behavioural ADC and frame-level expectations.
module tb_adc_spi_rx;
  localparam int HALF = 2, CONVLEN = 4, NBITS = 34;
  // start-detect cycle to valid cycle: CONVLEN + HALF + 2*HALF*NBITS + 1
  localparam int LAT = CONVLEN + HALF + 2 * HALF * NBITS + 1;

  logic clock = 1'b0, reset_n = 1'b0, clockenable = 1'b0, miso = 1'b0;
  logic adcconv, sck, valid, busy;
  logic [13:0] datos_a, datos_b;

  adc_spi_rx #(.HALF(HALF), .CONVLEN(CONVLEN)) dut (
    .clock(clock), .reset_n(reset_n), .clockenable(clockenable), .miso(miso),
    .adcconv(adcconv), .sck(sck), .datos_a(datos_a), .datos_b(datos_b),
    .valid(valid), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [33:0] mkfrm(input logic [13:0] a, input logic [13:0] b, input logic [5:0] pd);
    return {pd[5:4], a, pd[3:2], b, pd[1:0]};
  endfunction

  // ADC model: first bit after conversion, next bit on each sck fall
  logic [33:0] frm = '0;
  int bidx = 0;
  always @(posedge adcconv or negedge sck) begin
    if (adcconv) begin
      bidx = 0;
      miso = frm[33];
    end else begin
      bidx++;
      if (bidx < NBITS) miso = frm[33-bidx];
      else miso = 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  int conv_cnt = 0, rises = 0, vcnt = 0, t_valid = 0, stable_err = 0;
  logic sck_p = 1'b0;
  logic [13:0] last_a = '0, last_b = '0;
  always @(negedge clock) begin
    if (adcconv) conv_cnt++;
    if (sck && !sck_p) rises++;
    sck_p = sck;
    if (valid) begin
      vcnt++;
      t_valid = cyc;
      last_a = datos_a;
      last_b = datos_b;
    end else if (!reset_n) begin
      last_a = '0;
      last_b = '0;
    end else if (datos_a !== last_a || datos_b !== last_b) stable_err++;
  end

  int t_start = 0;

  task automatic wait_valid(input int v0);
    int k = 0;
    while (vcnt == v0 && k < 400) begin
      @(negedge clock);
      k++;
    end
  endtask

  task automatic run_frame(input logic [13:0] a, input logic [13:0] b, input logic [5:0] pd, input string tag);
    int c0, r0, v0;
    frm = mkfrm(a, b, pd);
    @(negedge clock);
    c0 = conv_cnt; r0 = rises; v0 = vcnt;
    clockenable = 1'b1;
    t_start = cyc;
    wait_valid(v0);
    repeat (5) @(negedge clock);
    clockenable = 1'b0;
    chk({tag, "_nvalid"}, vcnt - v0, 1);
    chk({tag, "_lat"}, t_valid - t_start, LAT);
    chk({tag, "_conv"}, conv_cnt - c0, CONVLEN);
    chk({tag, "_rises"}, rises - r0, NBITS);
    chk({tag, "_a"}, {18'h0, datos_a}, {18'h0, a});
    chk({tag, "_b"}, {18'h0, datos_b}, {18'h0, b});
    chk({tag, "_busy"}, {31'h0, busy}, 0);
  endtask

  initial begin
    int c0, r0, v0, k;
    logic [13:0] ra, rb;

    #100;
    reset_n = 1'b1;
    c0 = conv_cnt; r0 = rises; v0 = vcnt;
    repeat (50) @(negedge clock);
    chk("rst_conv", conv_cnt - c0, 0);
    chk("rst_rises", rises - r0, 0);
    chk("rst_valid", vcnt - v0, 0);
    chk("rst_out", {busy, sck, adcconv, valid, datos_a, datos_b}, 0);

    run_frame(14'h1234, 14'h2DCB, 6'b000000, "basic");
    run_frame(14'h2000, 14'h1FFF, 6'b111111, "signpad");
    repeat (3) begin
      ra = 14'($urandom); rb = 14'($urandom);
      run_frame(ra, rb, 6'($urandom), "rand");
    end

    // extra strobe mid-frame must be dropped
    frm = mkfrm(14'h0F0F, 14'h3C3C, 6'b101010);
    @(negedge clock);
    c0 = conv_cnt; v0 = vcnt;
    clockenable = 1'b1;
    repeat (3) @(negedge clock);
    clockenable = 1'b0;
    repeat (47) @(negedge clock);
    clockenable = 1'b1;
    @(negedge clock);
    chk("extra_busy", {31'h0, busy}, 1);
    wait_valid(v0);
    repeat (200) @(negedge clock);
    clockenable = 1'b0;
    chk("extra_nvalid", vcnt - v0, 1);
    chk("extra_conv", conv_cnt - c0, CONVLEN);
    chk("extra_a", {18'h0, datos_a}, 32'h0F0F);
    chk("extra_b", {18'h0, datos_b}, 32'h3C3C);

    // reset during SHIFT aborts the frame
    frm = mkfrm(14'h1111, 14'h2222, 6'b0);
    @(negedge clock);
    r0 = rises; v0 = vcnt;
    clockenable = 1'b1;
    k = 0;
    while (rises - r0 < 20 && k < 400) begin
      @(negedge clock);
      k++;
    end
    chk("abort_reach20", rises - r0, 20);
    reset_n = 1'b0;
    #1;
    chk("abort_out", {busy, sck, adcconv, valid}, 0);
    clockenable = 1'b0;
    repeat (10) @(negedge clock);
    reset_n = 1'b1;
    repeat (200) @(negedge clock);
    chk("abort_novalid", vcnt - v0, 0);
    chk("abort_datos", {datos_a, datos_b}, 0);
    rb = 14'($urandom);
    run_frame(14'h0AAA, rb, 6'($urandom), "postrst");

    // slow square wave on clockenable: one frame per rising edge
    v0 = vcnt; k = stable_err;
    ra = '0; rb = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (!clockenable) begin
        ra = 14'($urandom); rb = 14'($urandom);
        frm = mkfrm(ra, rb, 6'($urandom));
      end
      clockenable = ~clockenable;
      repeat (339) @(negedge clock);
    end
    clockenable = 1'b0;
    chk("sq_nvalid", vcnt - v0, 3);
    chk("sq_a", {18'h0, datos_a}, {18'h0, ra});
    chk("sq_b", {18'h0, datos_b}, {18'h0, rb});
    chk("sq_stable", stable_err - k, 0);
    chk("stable_all", stable_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
